// File: rtl/small_comb_logic_pipe_sv.sv
// small_comb_logic_pipe_sv
// Two-stage elastic pipeline around a small set of logic/arithmetic functions.
// Stage 1 captures the incoming beat (data + op); stage 2 holds the computed
// result. The running accumulator is committed exactly when an ACC beat moves
// from stage 1 into stage 2, so it never changes on a stalled beat.
module small_comb_logic_pipe_sv #(
    parameter int DW    = 8,   // data width, even and >= 4
    parameter int ACC_W = 16   // accumulator width, >= DW
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    d_in,
    input  logic [2:0]       op,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    d_out,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    localparam int H = DW / 2;

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_INV  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SUM  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_PAR  = 3'd6,
        OP_ACC  = 3'd7
    } op_e;

    // Stage 1: captured beat
    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_data_q,  s1_data_d;
    op_e           s1_op_q,    s1_op_d;

    // Stage 2: computed result
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_data_q,  s2_data_d;

    // Accumulator state
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    // Pipeline control
    logic s2_load;
    logic s1_load;
    logic acc_adv;

    // Accumulator datapath
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_sum;

    // Function datapath
    logic [H-1:0]  op_a, op_b;
    logic [H:0]    sum_ab;
    logic [DW-1:0] result;

    // Elastic handshake: a stage may load when it is empty or its contents
    // move on in this same cycle. in_ready is combinational from out_ready.
    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        in_ready = s1_load;
    end

    // Stage 1 next state: capture a new beat whenever stage 1 frees up.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_op_d    = s1_op_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = d_in;
                s1_op_d   = op_e'(op);
            end
        end
    end

    // Accumulator next state: clear applies before the add, so a clear in
    // the same cycle as an ACC advance restarts from the incoming data.
    always_comb begin
        acc_adv  = s2_load && s1_valid_q && (s1_op_q == OP_ACC);
        acc_base = clr_acc ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + {1'b0, ACC_W'(s1_data_q)};
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        if (acc_adv) begin
            acc_d = acc_sum[ACC_W-1:0];
            ovf_d = (ovf_q && !clr_acc) || acc_sum[ACC_W];
        end else if (clr_acc) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Result of the beat sitting in stage 1, zero-extended to DW.
    always_comb begin
        op_a   = s1_data_q[H-1:0];
        op_b   = s1_data_q[DW-1:H];
        sum_ab = {1'b0, op_a} + {1'b0, op_b};
        result = '0;
        case (s1_op_q)
            OP_PASS: result = s1_data_q;
            OP_INV:  result = ~s1_data_q;
            OP_XOR:  result = DW'(op_a ^ op_b);
            OP_SUM:  result = DW'(sum_ab);
            OP_AND:  result = DW'(&s1_data_q);
            OP_OR:   result = DW'(|s1_data_q);
            OP_PAR:  result = DW'(^s1_data_q);
            OP_ACC:  result = acc_sum[DW-1:0];
            default: result = '0;
        endcase
    end

    // Stage 2 next state: take stage 1's result whenever stage 2 frees up.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = result;
            end
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_op_q    <= OP_PASS;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_op_q    <= s1_op_d;
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    // Accumulator and sticky overflow registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign d_out     = s2_data_q;
    assign acc       = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_small_comb_logic_pipe_sv.sv
// Scoreboard bench for small_comb_logic_pipe_sv: the driver pushes the
// reference result of each accepted beat; a monitor pops on every delivery.
module tb_small_comb_logic_pipe_sv;

    localparam int DW    = 8;
    localparam int ACC_W = 16;
    localparam int H     = DW / 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    d_in = '0;
    logic [2:0]       op = 3'd0;
    logic             clr_acc = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [DW-1:0]    d_out;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    always #5 clk = ~clk;

    small_comb_logic_pipe_sv #(.DW(DW), .ACC_W(ACC_W)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .d_in(d_in), .op(op), .clr_acc(clr_acc),
        .out_valid(out_valid), .out_ready(out_ready),
        .d_out(d_out), .acc(acc), .ovf(ovf)
    );

    typedef struct {
        logic [DW-1:0]    d;
        logic [ACC_W-1:0] a;
        logic             o;
    } exp_t;

    exp_t          exp_q[$];
    int            vectors = 0;
    int            errors  = 0;
    int            cyc     = 0;
    int            acc_cyc[$];
    int            del_cyc[$];
    logic [DW-1:0] last_dout = '0;
    bit            rnd_mode = 1'b0;

    // reference accumulator state
    longint        acc_m = 0;
    bit            ovf_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain arithmetic on the beat value.
    task automatic model_push(input logic [DW-1:0] d, input logic [2:0] o, input bit clr);
        longint dv   = longint'(d);
        longint lo   = dv % (longint'(1) << H);
        longint hi   = dv / (longint'(1) << H);
        longint full = longint'(1) << DW;
        longint lim  = longint'(1) << ACC_W;
        longint r    = 0;
        exp_t   e;
        case (o)
            3'd0: r = dv;
            3'd1: r = full - 1 - dv;
            3'd2: r = lo ^ hi;
            3'd3: r = lo + hi;
            3'd4: r = (dv == full - 1) ? 1 : 0;
            3'd5: r = (dv != 0) ? 1 : 0;
            3'd6: r = $countones(d) % 2;
            default: begin
                if (clr) begin
                    acc_m = 0;
                    ovf_m = 1'b0;
                end
                acc_m = acc_m + dv;
                if (acc_m >= lim) begin
                    acc_m = acc_m - lim;
                    ovf_m = 1'b1;
                end
                r = acc_m % full;
            end
        endcase
        e.d = DW'(r);
        e.a = ACC_W'(acc_m);
        e.o = ovf_m;
        exp_q.push_back(e);
    endtask

    // Offer one beat until accepted; optionally hold clr_acc in the cycle the
    // beat advances into stage 2 (requires out_ready=1 and an empty pipe).
    task automatic send(input logic [DW-1:0] d, input logic [2:0] o, input bit clr_adv);
        bit done = 1'b0;
        in_valid = 1'b1;
        d_in     = d;
        op       = o;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                model_push(d, o, clr_adv);
                acc_cyc.push_back(cyc);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        if (clr_adv) begin
            clr_acc = 1'b1;
            @(posedge clk);
            #1;
            clr_acc = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Standalone clear, only issued while nothing is in flight.
    task automatic pulse_clear();
        clr_acc = 1'b1;
        acc_m   = 0;
        ovf_m   = 1'b0;
        @(posedge clk);
        #1;
        clr_acc = 1'b0;
    endtask

    // Monitor: every delivered beat is compared with the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn && out_valid && out_ready) begin
            del_cyc.push_back(cyc);
            last_dout = d_out;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(d_out), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("d_out", 64'(d_out), 64'(e.d));
                chk("acc",   64'(acc),   64'(e.a));
                chk("ovf",   64'(ovf),   64'(e.o));
            end
        end
    end

    // Random backpressure while in random mode.
    always @(posedge clk) begin
        #1;
        if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] fd[9]  = '{8'h35, 8'h35, 8'h35, 8'h35, 8'h35, 8'h35, 8'h35, 8'hFF, 8'hFF};
    logic [2:0] fo[9]  = '{3'd0,  3'd1,  3'd2,  3'd3,  3'd4,  3'd5,  3'd6,  3'd3,  3'd4};
    logic [7:0] fe[9]  = '{8'h35, 8'hCA, 8'h06, 8'h08, 8'h00, 8'h01, 8'h00, 8'h1E, 8'h01};
    logic [7:0] bp[4]  = '{8'h41, 8'h42, 8'h43, 8'h44};

    initial begin
        int idx;
        // ---------------- reset state ----------------
        #2 resetn = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_d_out",     64'(d_out),     64'd0);
        chk("rst_acc",       64'(acc),       64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- function table ----------------
        for (int i = 0; i < 9; i++) begin
            send(fd[i], fo[i], 1'b0);
            drain();
            chk("func_const", 64'(last_dout), 64'(fe[i]));
        end

        // ---------------- latency / throughput ----------------
        // Cycle stamps are the posedge count at the negedge sample: a beat
        // handshaken in cycle c is first visible at the output in cycle c+2.
        acc_cyc.delete();
        del_cyc.delete();
        for (int i = 0; i < 10; i++) send(8'(i), 3'd0, 1'b0);
        drain();
        chk("tp_count", 64'(del_cyc.size()), 64'd10);
        if (del_cyc.size() == 10 && acc_cyc.size() == 10) begin
            chk("latency", 64'(del_cyc[0] - acc_cyc[0]), 64'd2);
            for (int i = 1; i < 10; i++) begin
                chk("in_b2b",  64'(acc_cyc[i] - acc_cyc[i-1]), 64'd1);
                chk("out_b2b", 64'(del_cyc[i] - del_cyc[i-1]), 64'd1);
            end
        end
        chk("tp_last", 64'(last_dout), 64'h09);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        idx       = 0;
        in_valid  = 1'b1;
        op        = 3'd0;
        d_in      = bp[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready && idx < 4) begin
                model_push(bp[idx], 3'd0, 1'b0);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 4) d_in = bp[idx];
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_d", 64'(d_out), 64'h41);
        @(posedge clk);
        #1;
        chk("bp_hold_d2", 64'(d_out), 64'h41);
        out_ready = 1'b1;
        send(bp[2], 3'd0, 1'b0);
        send(bp[3], 3'd0, 1'b0);
        drain();
        chk("bp_last", 64'(last_dout), 64'h44);

        // ---------------- accumulator ----------------
        pulse_clear();
        chk("acc_cleared", 64'(acc), 64'd0);
        send(8'h10, 3'd7, 1'b0);
        send(8'h20, 3'd7, 1'b0);
        send(8'hF0, 3'd7, 1'b0);
        drain();
        chk("acc_sum",  64'(acc), 64'h0120);
        chk("acc_ovf0", 64'(ovf), 64'd0);
        chk("acc_dout", 64'(last_dout), 64'h20);

        // ---------------- overflow and clear ----------------
        for (int i = 0; i < 256; i++) send(8'hFF, 3'd7, 1'b0);
        drain();
        chk("ovf_acc", 64'(acc), 64'h0020);
        chk("ovf_set", 64'(ovf), 64'd1);
        send(8'h05, 3'd7, 1'b0);
        drain();
        chk("ovf_sticky_acc", 64'(acc), 64'h0025);
        chk("ovf_sticky",     64'(ovf), 64'd1);
        send(8'h07, 3'd7, 1'b1);
        drain();
        chk("clr_add_acc", 64'(acc), 64'h0007);
        chk("clr_add_ovf", 64'(ovf), 64'd0);
        chk("clr_add_d",   64'(last_dout), 64'h07);

        // ---------------- reset mid-stream ----------------
        pulse_clear();
        send(8'h10, 3'd7, 1'b0);
        send(8'h20, 3'd7, 1'b0);
        drain();
        chk("pre_rst_acc", 64'(acc), 64'h0030);
        out_ready = 1'b0;
        send(8'h01, 3'd0, 1'b0);
        send(8'h02, 3'd0, 1'b0);
        #1 resetn = 1'b0;
        #1;
        exp_q.delete();
        acc_m = 0;
        ovf_m = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_d_out",     64'(d_out),     64'd0);
        chk("mid_rst_acc",       64'(acc),       64'd0);
        chk("mid_rst_ovf",       64'(ovf),       64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1 resetn = 1'b1;
        out_ready = 1'b1;
        acc_cyc.delete();
        del_cyc.delete();
        send(8'hAB, 3'd0, 1'b0);
        drain();
        chk("post_rst_count", 64'(del_cyc.size()), 64'd1);
        if (del_cyc.size() == 1 && acc_cyc.size() == 1)
            chk("post_rst_latency", 64'(del_cyc[0] - acc_cyc[0]), 64'd2);
        chk("post_rst_d", 64'(last_dout), 64'hAB);

        // ---------------- random traffic ----------------
        rnd_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0 && exp_q.size() == 0) pulse_clear();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 3'($urandom), 1'b0);
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
